branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and resolution checker for the 5-stage MIPS pipeline. At IF it looks up the fetch PC in a direct-mapped table of 2-bit saturating counters plus a tagged target buffer and supplies the predicted next PC. At EX it takes the resolved branch outcome from the branch comparator, trains the tables, and raises a flush with the correct redirect PC on a misprediction. It also keeps saturating branch and mispredict statistics counters.

## Interface

Parameters:
- INDEX_BITS, 6, table index width; there are 2^INDEX_BITS entries.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_valid  input  1  IF stage holds a real fetch.
- if_pc  input  32  fetch PC (word aligned).
- pred_taken  output  1  IF prediction: branch taken.
- pred_next_pc  output  32  predicted next fetch PC.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch (Branch code != 3'b000).
- ex_taken  input  1  resolved outcome (Branch_ok).
- ex_pc  input  32  PC of the EX branch.
- ex_target  input  32  computed branch target.
- ex_pred_taken  input  1  pred_taken carried down the pipeline with this instruction.
- ex_pred_next_pc  input  32  pred_next_pc carried down with this instruction.
- flush  output  1  misprediction: squash IF/ID and redirect.
- redirect_pc  output  32  correct next PC when flush=1.
- branch_cnt  output  16  resolved branches, saturating.
- mispredict_cnt  output  16  mispredictions, saturating.

## Operation

- Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]. Storage per entry: 2-bit counter, BTB valid bit, tag, 32-bit target.
- Lookup (combinational): hit = btb_valid[idx] && btb_tag[idx] == tag(if_pc). pred_taken = if_valid && hit && counter[idx][1]. pred_next_pc = pred_taken ? btb_target[idx] : if_pc + 4 (32-bit wrap; 0xFFFFFFFC+4 = 0).
- Resolution (combinational): correct_next = ex_taken ? ex_target : ex_pc + 4. flush = ex_valid && ex_is_branch && (ex_pred_next_pc != correct_next). redirect_pc = correct_next whenever ex_valid && ex_is_branch, else 0.
- Training (rising edge, when ex_valid && ex_is_branch):
  - Counter at idx(ex_pc): taken -> increment, saturate at 2'b11; not taken -> decrement, saturate at 2'b00. States: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Taken: BTB entry written valid=1, tag(ex_pc), ex_target (overwrites any aliasing entry). Not taken: BTB untouched.
  - branch_cnt += 1 saturating at 0xFFFF; mispredict_cnt += 1 saturating at 0xFFFF when flush.
- Non-branch or ex_valid=0: no state change, flush=0.
- Same-cycle lookup and update to the same index: lookup returns pre-edge contents; no bypass.

## Timing

- Lookup and resolution outputs are zero-latency combinational; training is visible to lookups starting the cycle after the update edge.
- flush is valid the same cycle as the EX branch; the pipeline loads redirect_pc into the PC on the following edge.
- Reset (async, any time, including mid-update): all counters 2'b01, all BTB valid bits 0, branch_cnt=0, mispredict_cnt=0. With if_valid=0 and ex_valid=0: pred_taken=0, flush=0, redirect_pc=0. pred_next_pc = if_pc+4 while no entry hits. Release takes effect at the first rising edge with rst_n=1.
- No internal pipelining; one update per cycle maximum.

## Test plan

- Reset then lookup if_pc=0x00400000 -> pred_taken=0, pred_next_pc=0x00400004; counters 0.
- Resolve taken branch ex_pc=0x00400010, ex_target=0x00400040, ex_pred_next_pc=0x00400014 -> flush=1, redirect_pc=0x00400040; next cycle counter=10, lookup 0x00400010 -> pred_taken=1, pred_next_pc=0x00400040.
- Same branch taken 3 more times correctly predicted -> flush=0, counter saturates at 11; then one not-taken -> flush=1, redirect_pc=0x00400014, counter=10, still predicts taken.
- Alias: taken branch at 0x00400110 (same index, different tag) -> BTB overwritten; lookup 0x00400010 -> hit=0, pred_next_pc=0x00400014.
- Drive 0x10000 mispredicting branches -> branch_cnt and mispredict_cnt hold 0xFFFF; ex_is_branch=0 cycles change nothing.
- Assert rst_n=0 asynchronously between edges during a training burst -> all outputs/counters return to reset values immediately; trained entries lost.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor and resolution checker for the 5-stage MIPS
//   pipeline. The IF side looks up a direct-mapped table of 2-bit saturating
//   counters plus a tagged target buffer and produces the predicted next PC.
//   The EX side checks the resolved outcome against the prediction that was
//   carried down the pipeline. It raises flush/redirect_pc on a mismatch and
//   trains the tables on the rising edge.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   if_valid, if_pc     : IF lookup request
//   pred_taken          : IF prediction (taken)
//   pred_next_pc        : IF predicted next fetch PC
//   ex_valid            : EX holds a real instruction
//   ex_is_branch        : EX instruction is a conditional branch
//   ex_taken            : resolved branch outcome
//   ex_pc, ex_target    : branch PC and computed target
//   ex_pred_taken       : prediction carried with the instruction
//   ex_pred_next_pc     : predicted next PC carried with the instruction
//   flush, redirect_pc  : misprediction squash and correct next PC
//   branch_cnt          : resolved branches (saturating)
//   mispredict_cnt      : mispredictions (saturating)
//
// Handshake: none. Every cycle with ex_valid && ex_is_branch is one update,
// and there is no back-pressure.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_next_pc,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispredict_cnt
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [1:0]          cnt_q        [ENTRIES];
  logic [1:0]          cnt_d        [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid_q, btb_valid_d;
  logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_d    [ENTRIES];
  logic [31:0]         btb_target_q [ENTRIES];
  logic [31:0]         btb_target_d [ENTRIES];
  logic [15:0]         branch_cnt_q, branch_cnt_d;
  logic [15:0]         mispredict_cnt_q, mispredict_cnt_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  if_hit;
  logic                  ex_update;
  logic [31:0]           correct_next;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];

  // Lookup reads only the registered tables. A same-cycle update to the same
  // index is therefore not visible until the following cycle.
  assign if_hit       = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
  assign pred_taken   = if_valid && if_hit && cnt_q[if_idx][1];
  assign pred_next_pc = pred_taken ? btb_target_q[if_idx] : if_pc + 32'd4;

  // The misprediction check compares next PCs rather than directions. This
  // also catches a taken prediction that used a stale or aliased target.
  assign ex_update    = ex_valid && ex_is_branch;
  assign correct_next = ex_taken ? ex_target : ex_pc + 32'd4;
  assign flush        = ex_update && (ex_pred_next_pc != correct_next);
  assign redirect_pc  = ex_update ? correct_next : 32'd0;

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  always_comb begin
    cnt_d            = cnt_q;
    btb_valid_d      = btb_valid_q;
    btb_tag_d        = btb_tag_q;
    btb_target_d     = btb_target_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (ex_update) begin
      if (ex_taken) begin
        if (cnt_q[ex_idx] != 2'b11) cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
        // A taken branch always claims its entry, evicting any alias.
        btb_valid_d[ex_idx]  = 1'b1;
        btb_tag_d[ex_idx]    = ex_tag;
        btb_target_d[ex_idx] = ex_target;
      end else begin
        if (cnt_q[ex_idx] != 2'b00) cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
      end
      if (branch_cnt_q != 16'hFFFF) branch_cnt_d = branch_cnt_q + 16'd1;
      if (flush && (mispredict_cnt_q != 16'hFFFF))
        mispredict_cnt_d = mispredict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i]        <= 2'b01;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
      btb_valid_q      <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      cnt_q            <= cnt_d;
      btb_valid_q      <= btb_valid_d;
      btb_tag_q        <= btb_tag_d;
      btb_target_q     <= btb_target_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Carried with the instruction for pipeline bookkeeping only. The resolution
  // check uses the carried next PC, which already encodes the direction.
  logic unused_ex_pred_taken;
  assign unused_ex_pred_taken = ex_pred_taken;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_next_pc = '0;
  logic        ex_pred_taken = 1'b0;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispredict_cnt;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_next_pc(ex_pred_next_pc),
    .flush(flush), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One entry per index: counter as a plain 0..3 integer, plus a target buffer.
  int          m_ctr [64];
  bit          m_val [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_br, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = '0;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_lookup(input logic v, input logic [31:0] pc,
                              output logic t, output logic [31:0] nxt);
    int i;
    i = idx_of(pc);
    t = v && m_val[i] && (m_tag[i] == (pc >> 8)) && (m_ctr[i] >= 2);
    nxt = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_resolve(output logic f, output logic [31:0] r);
    logic [31:0] good;
    good = ex_taken ? ex_target : ex_pc + 32'd4;
    f = ex_valid && ex_is_branch && (ex_pred_next_pc != good);
    r = (ex_valid && ex_is_branch) ? good : 32'd0;
  endtask

  task automatic model_train();
    logic f;
    logic [31:0] r;
    int i;
    if (!(ex_valid && ex_is_branch)) return;
    model_resolve(f, r);
    i = idx_of(ex_pc);
    if (ex_taken) begin
      m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
      m_val[i] = 1; m_tag[i] = ex_pc >> 8; m_tgt[i] = ex_target;
    end else begin
      m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
    end
    if (m_br < 65535) m_br++;
    if (f && m_mis < 65535) m_mis++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [31:0] ipc,
                       input logic ev, input logic eb, input logic et,
                       input logic [31:0] epc, input logic [31:0] etg,
                       input logic [31:0] epn);
    if_valid = iv; if_pc = ipc;
    ex_valid = ev; ex_is_branch = eb; ex_taken = et;
    ex_pc = epc; ex_target = etg; ex_pred_next_pc = epn;
    ex_pred_taken = (epn != epc + 32'd4);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        iv;
    logic [31:0] ipc;
    logic        ev, eb, et;
    logic [31:0] epc, etg, epn;
    logic        e_pt;
    logic [31:0] e_pnp;
    logic        e_fl;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic iv, input logic [31:0] ipc,
                              input logic ev, input logic eb, input logic et,
                              input logic [31:0] epc, input logic [31:0] etg,
                              input logic [31:0] epn, input logic e_pt,
                              input logic [31:0] e_pnp, input logic e_fl,
                              input logic [31:0] e_rd);
    vec_t v;
    v.iv = iv; v.ipc = ipc; v.ev = ev; v.eb = eb; v.et = et;
    v.epc = epc; v.etg = etg; v.epn = epn;
    v.e_pt = e_pt; v.e_pnp = e_pnp; v.e_fl = e_fl; v.e_rd = e_rd;
    return v;
  endfunction

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0110;

  initial begin
    logic        t, f;
    logic [31:0] nx, rd;

    vecs[0]  = mk(1, 32'h0040_0000, 0,0,0, 0, 0, 0,              0, 32'h0040_0004, 0, 0);
    vecs[1]  = mk(1, PA, 1,1,1, PA, 32'h0040_0040, 32'h0040_0014, 0, 32'h0040_0014, 1, 32'h0040_0040);
    vecs[2]  = mk(1, PA, 1,1,1, PA, 32'h0040_0040, 32'h0040_0040, 1, 32'h0040_0040, 0, 32'h0040_0040);
    vecs[3]  = mk(1, PA, 1,1,1, PA, 32'h0040_0040, 32'h0040_0040, 1, 32'h0040_0040, 0, 32'h0040_0040);
    vecs[4]  = mk(1, PA, 1,1,1, PA, 32'h0040_0040, 32'h0040_0040, 1, 32'h0040_0040, 0, 32'h0040_0040);
    vecs[5]  = mk(1, PA, 1,1,0, PA, 32'h0040_0040, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0014);
    vecs[6]  = mk(1, PA, 0,0,0, 0, 0, 0,                          1, 32'h0040_0040, 0, 0);
    vecs[7]  = mk(1, PA, 1,1,0, PA, 32'h0040_0040, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0014);
    vecs[8]  = mk(1, PA, 0,0,0, 0, 0, 0,                          0, 32'h0040_0014, 0, 0);
    vecs[9]  = mk(1, PA, 1,1,1, PB, 32'h0040_0200, 32'h0040_0114, 0, 32'h0040_0014, 1, 32'h0040_0200);
    vecs[10] = mk(1, PA, 0,0,0, 0, 0, 0,                          0, 32'h0040_0014, 0, 0);
    vecs[11] = mk(1, PB, 0,0,0, 0, 0, 0,                          1, 32'h0040_0200, 0, 0);
    vecs[12] = mk(1, 32'hFFFF_FFFC, 1,0,1, PA, 32'h0040_0300, 32'h0, 0, 32'h0, 0, 0);
    vecs[13] = mk(1, PB, 0,1,1, PA, 32'h0040_0300, 32'h0,         1, 32'h0040_0200, 0, 0);
    vecs[14] = mk(1, PA, 0,0,0, 0, 0, 0,                          0, 32'h0040_0014, 0, 0);
    vecs[15] = mk(0, PB, 0,0,0, 0, 0, 0,                          0, 32'h0040_0114, 0, 0);

    // Reset state, with the clock running and reset still asserted.
    #12;
    check32("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check32("rst_flush", {31'd0, flush}, 32'd0);
    check32("rst_redirect", redirect_pc, 32'd0);
    check32("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check32("rst_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed sequence. Each row is one cycle.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].iv, vecs[i].ipc, vecs[i].ev, vecs[i].eb, vecs[i].et,
            vecs[i].epc, vecs[i].etg, vecs[i].epn);
      @(negedge clk);
      check32($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
      check32($sformatf("v%0d_pred_next_pc", i), pred_next_pc, vecs[i].e_pnp);
      check32($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_fl});
      check32($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rd);
    end
    check32("tbl_branch_cnt", {16'd0, branch_cnt}, 32'd7);
    check32("tbl_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd4);

    // Statistics saturation: 0x10000 mispredicting not-taken branches.
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk); #1;
      drive(0, 32'h0, 1, 1, 0, 32'h0040_0080, 32'h0040_0090, 32'h0040_0088);
    end
    @(negedge clk);
    check32("sat_flush", {31'd0, flush}, 32'd1);
    @(posedge clk); #1;
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check32("sat_branch_cnt", {16'd0, branch_cnt}, 32'h0000_FFFF);
    check32("sat_mispredict_cnt", {16'd0, mispredict_cnt}, 32'h0000_FFFF);

    // Non-branch cycles with EX valid must not train anything.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1, PA, 1, 0, 1, PA, 32'h0040_0300, 32'h0);
    end
    @(posedge clk); #1;
    drive(1, PA, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check32("nb_pred_next_pc_a", pred_next_pc, 32'h0040_0014);
    @(posedge clk); #1;
    if_pc = PB;
    @(negedge clk);
    check32("nb_pred_next_pc_b", pred_next_pc, 32'h0040_0200);
    check32("nb_branch_cnt", {16'd0, branch_cnt}, 32'h0000_FFFF);

    // Asynchronous reset in the middle of a training burst.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1, 32'h0040_0020, 1, 1, 1, 32'h0040_0020, 32'h0040_0500, 32'h0040_0500);
    end
    @(negedge clk);
    check32("pre_areset_pred", pred_next_pc, 32'h0040_0500);
    check32("pre_areset_cnt", {16'd0, branch_cnt}, 32'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check32("areset_pred_taken", {31'd0, pred_taken}, 32'd0);
    check32("areset_pred_next_pc", pred_next_pc, 32'h0040_0024);
    check32("areset_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check32("areset_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd0);
    drive(1, 32'h0040_0020, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check32("post_areset_pred", pred_next_pc, 32'h0040_0024);

    // Randomized phase against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        iv, ev, eb, et;
      logic [31:0] ipc, epc, etg, epn;
      iv  = ($urandom_range(0, 7) != 0);
      ipc = 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 15)) << 2);
      ev  = ($urandom_range(0, 7) != 0);
      eb  = ($urandom_range(0, 3) != 0);
      et  = $urandom_range(0, 1);
      epc = 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 15)) << 2);
      etg = {4'h0, 28'($urandom) & 28'hFFF_FFFC};
      case ($urandom_range(0, 2))
        0: begin model_lookup(1'b1, epc, t, nx); epn = nx; end
        1: epn = epc + 32'd4;
        default: epn = etg;
      endcase
      @(posedge clk); #1;
      drive(iv, ipc, ev, eb, et, epc, etg, epn);
      @(negedge clk);
      model_lookup(iv, ipc, t, nx);
      model_resolve(f, rd);
      check32("rnd_pred_taken", {31'd0, pred_taken}, {31'd0, t});
      check32("rnd_pred_next_pc", pred_next_pc, nx);
      check32("rnd_flush", {31'd0, flush}, {31'd0, f});
      check32("rnd_redirect_pc", redirect_pc, rd);
      check32("rnd_branch_cnt", {16'd0, branch_cnt}, 32'(m_br));
      check32("rnd_mispredict_cnt", {16'd0, mispredict_cnt}, 32'(m_mis));
      model_train();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
